// File: rtl/mcf_pkg.sv
// -----------------------------------------------------------------------------
// mcf_pkg
// Shared definitions for the multi-channel packet formatter (mc_formatter).
//   - mcf_state_e      : formatter FSM state encoding
//   - MCF_HDR_*_SLOT   : header field positions, counted in LENW-wide slots
//                        from the MSB of the output word
//   - MCF_*_DEFAULT    : default widths
// Configuration macro: MCF_PARITY_EN (adds the trailing PARITY state).
// -----------------------------------------------------------------------------
package mcf_pkg;

  localparam int MCF_DW_DEFAULT   = 32;
  localparam int MCF_LENW_DEFAULT = 8;

  // Header word layout: {id, len, zeros}; id occupies the top slot.
  localparam int MCF_HDR_ID_SLOT  = 0;
  localparam int MCF_HDR_LEN_SLOT = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3
`ifdef MCF_PARITY_EN
    ,
    ST_PARITY  = 3'd4
`endif
  } mcf_state_e;

  // MSB bit position of a header slot for a given word/field width.
  function automatic int mcf_slot_msb(input int dw, input int lenw, input int slot);
    return dw - 1 - slot * lenw;
  endfunction

endpackage

// File: rtl/mcf_rr_arb.sv
// -----------------------------------------------------------------------------
// mcf_rr_arb
// Round-robin arbiter. The grant is a combinational one-hot pick of the first
// requester at or after the priority pointer; the pointer moves to the channel
// after the winner when advance_i is pulsed. Reset gives channel 0 top priority.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   req_i      request vector, one bit per channel
//   advance_i  commit the current grant and rotate priority
//   grant_o    one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module mcf_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win_idx;
  logic          w_any;

  // Scan N positions starting at the pointer, wrapping at N (N need not be a
  // power of two, so the wrap is explicit rather than a modulo on PW bits).
  always_comb begin
    int idx;
    grant_o   = '0;
    w_win_idx = '0;
    w_any     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!w_any && req_i[idx]) begin
        w_any        = 1'b1;
        grant_o[idx] = 1'b1;
        w_win_idx    = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (advance_i && w_any) begin
      r_ptr <= (w_win_idx == PW'(N - 1)) ? '0 : w_win_idx + PW'(1);
    end
  end

endmodule

// File: rtl/mc_formatter.sv
// -----------------------------------------------------------------------------
// mc_formatter
// Multi-channel packet formatter. Picks a requesting channel round-robin,
// emits a header word {id, len, 0}, then exactly len payload words popped from
// that channel, then (optionally) an XOR parity word covering header+payload.
// Configuration macro: MCF_PARITY_EN
//   defined   : trailing PARITY word carries pkg_lst_o
//   undefined : no parity; pkg_lst_o rides on the last payload word (or on the
//               header when len = 0)
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   data_slv_i  CH_NUM*DW   channel payload words
//   id_slv_i    CH_NUM*LENW channel packet ids
//   len_slv_i   CH_NUM*LENW channel payload word counts
//   req_vec_i   CH_NUM      channel has a payload word available
//   fetch_vec_o CH_NUM      one-hot pop pulse on each accepted payload word
//   rev_rdy_i               receiver ready
//   pkg_vld_o/pkg_dat_o/pkg_fst_o/pkg_lst_o  output word stream
//   busy_o                  packet in progress
//   cur_ch_o                granted channel index (valid while busy_o)
// -----------------------------------------------------------------------------
module mc_formatter
  import mcf_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DW     = MCF_DW_DEFAULT,
  parameter int LENW   = MCF_LENW_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CH_NUM*DW-1:0]      data_slv_i,
  input  logic [CH_NUM*LENW-1:0]    id_slv_i,
  input  logic [CH_NUM*LENW-1:0]    len_slv_i,
  input  logic [CH_NUM-1:0]         req_vec_i,
  output logic [CH_NUM-1:0]         fetch_vec_o,
  input  logic                      rev_rdy_i,
  output logic                      pkg_vld_o,
  output logic [DW-1:0]             pkg_dat_o,
  output logic                      pkg_fst_o,
  output logic                      pkg_lst_o,
  output logic                      busy_o,
  output logic [$clog2(CH_NUM)-1:0] cur_ch_o
);

  localparam int CW      = $clog2(CH_NUM);
  localparam int ID_MSB  = mcf_slot_msb(DW, LENW, MCF_HDR_ID_SLOT);
  localparam int LEN_MSB = mcf_slot_msb(DW, LENW, MCF_HDR_LEN_SLOT);

  mcf_state_e        r_state;
  logic [CH_NUM-1:0] r_grant;
  logic [LENW-1:0]   r_id;
  logic [LENW-1:0]   r_len;
  logic [LENW-1:0]   r_cnt;
`ifdef MCF_PARITY_EN
  logic [DW-1:0]     r_par;
`endif

  logic [CH_NUM-1:0] w_arb_grant;
  logic [CH_NUM-1:0] w_idx_src;
  logic [LENW-1:0]   w_id_arb;
  logic [LENW-1:0]   w_len_arb;
  logic [DW-1:0]     w_dat_sel;
  logic [CW-1:0]     w_gnt_idx;
  logic [DW-1:0]     w_hdr;
  logic              w_req_gnt;
  logic              w_xfer;
  logic              w_arb;

  assign w_arb = (r_state == ST_ARB);

  mcf_rr_arb #(.N(CH_NUM)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_vec_i),
    .advance_i (w_arb),
    .grant_o   (w_arb_grant)
  );

  // During ARB the grant is not latched yet, so report the arbiter's pick so
  // that cur_ch_o is meaningful in every busy state.
  assign w_idx_src = w_arb ? w_arb_grant : r_grant;

  // One-hot muxes: id/len follow the live arbiter pick (latched in ARB),
  // payload data follows the latched grant.
  always_comb begin
    w_id_arb  = '0;
    w_len_arb = '0;
    w_dat_sel = '0;
    w_gnt_idx = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (w_arb_grant[k]) begin
        w_id_arb  = w_id_arb  | id_slv_i[k*LENW +: LENW];
        w_len_arb = w_len_arb | len_slv_i[k*LENW +: LENW];
      end
      if (r_grant[k]) begin
        w_dat_sel = w_dat_sel | data_slv_i[k*DW +: DW];
      end
      if (w_idx_src[k]) begin
        w_gnt_idx = w_gnt_idx | CW'(k);
      end
    end
  end

  always_comb begin
    w_hdr                     = '0;
    w_hdr[ID_MSB  -: LENW]    = r_id;
    w_hdr[LEN_MSB -: LENW]    = r_len;
  end

  assign w_req_gnt = |(req_vec_i & r_grant);

  always_comb begin
    pkg_vld_o = 1'b0;
    pkg_dat_o = '0;
    pkg_fst_o = 1'b0;
    pkg_lst_o = 1'b0;
    case (r_state)
      ST_HEADER: begin
        pkg_vld_o = 1'b1;
        pkg_dat_o = w_hdr;
        pkg_fst_o = 1'b1;
`ifndef MCF_PARITY_EN
        pkg_lst_o = (r_len == '0);
`endif
      end
      ST_PAYLOAD: begin
        // A withdrawn request simply stalls the packet.
        pkg_vld_o = w_req_gnt;
        pkg_dat_o = w_dat_sel;
`ifndef MCF_PARITY_EN
        pkg_lst_o = w_req_gnt && (r_cnt == LENW'(1));
`endif
      end
`ifdef MCF_PARITY_EN
      ST_PARITY: begin
        pkg_vld_o = 1'b1;
        pkg_dat_o = r_par;
        pkg_lst_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign w_xfer      = pkg_vld_o && rev_rdy_i;
  assign fetch_vec_o = ((r_state == ST_PAYLOAD) && w_xfer) ? r_grant : '0;
  assign busy_o      = (r_state != ST_IDLE);
  assign cur_ch_o    = busy_o ? w_gnt_idx : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
`ifdef MCF_PARITY_EN
      r_par   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_vec_i) r_state <= ST_ARB;
        end
        ST_ARB: begin
          // A request withdrawn before ARB leaves nothing to grant; fall back
          // to IDLE instead of starting a packet with no owner.
          if (|w_arb_grant) begin
            r_grant <= w_arb_grant;
            r_id    <= w_id_arb;
            r_len   <= w_len_arb;
            r_state <= ST_HEADER;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HEADER: begin
          if (w_xfer) begin
            r_cnt <= r_len;
`ifdef MCF_PARITY_EN
            r_par <= w_hdr;
            r_state <= (r_len != '0) ? ST_PAYLOAD : ST_PARITY;
`else
            r_state <= (r_len != '0) ? ST_PAYLOAD : ST_IDLE;
`endif
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            r_cnt <= r_cnt - LENW'(1);
`ifdef MCF_PARITY_EN
            r_par <= r_par ^ w_dat_sel;
            if (r_cnt == LENW'(1)) r_state <= ST_PARITY;
`else
            if (r_cnt == LENW'(1)) r_state <= ST_IDLE;
`endif
          end
        end
`ifdef MCF_PARITY_EN
        ST_PARITY: begin
          if (w_xfer) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_formatter.sv
// -----------------------------------------------------------------------------
// tb_mc_formatter
// Directed scenarios followed by randomized traffic. Channels are modelled as
// packet queues; the expected word stream of each packet is built from the
// packet contents (header, payload, XOR parity) and compared word by word.
// Honors MCF_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mc_formatter;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int LW = 8;
`ifdef MCF_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic [CH*DW-1:0]  data_slv_i;
  logic [CH*LW-1:0]  id_slv_i;
  logic [CH*LW-1:0]  len_slv_i;
  logic [CH-1:0]     req_vec_i;
  logic [CH-1:0]     fetch_vec_o;
  logic              rev_rdy_i;
  logic              pkg_vld_o;
  logic [DW-1:0]     pkg_dat_o;
  logic              pkg_fst_o;
  logic              pkg_lst_o;
  logic              busy_o;
  logic [1:0]        cur_ch_o;

  always #5 clk = ~clk;

  mc_formatter #(.CH_NUM(CH), .DW(DW), .LENW(LW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_slv_i  (data_slv_i),
    .id_slv_i    (id_slv_i),
    .len_slv_i   (len_slv_i),
    .req_vec_i   (req_vec_i),
    .fetch_vec_o (fetch_vec_o),
    .rev_rdy_i   (rev_rdy_i),
    .pkg_vld_o   (pkg_vld_o),
    .pkg_dat_o   (pkg_dat_o),
    .pkg_fst_o   (pkg_fst_o),
    .pkg_lst_o   (pkg_lst_o),
    .busy_o      (busy_o),
    .cur_ch_o    (cur_ch_o)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            f;
    bit            l;
    bit            pay;
  } word_t;

  // Channel model
  logic [DW-1:0] ch_words [CH][$];
  logic [LW-1:0] ch_id    [CH][$];
  logic [LW-1:0] ch_len   [CH][$];
  bit            en       [CH];
  bit            scr      [CH];
  logic [LW-1:0] scr_id   [CH];
  logic [LW-1:0] scr_len  [CH];

  // Packet model
  word_t exp_q[$];
  word_t obs_log[$];
  int    win_log[$];
  bit    active, arb_ph, want_idle;
  int    act_ch, act_len, last_win, pay_done, fetch_cnt;
  int    fcount [CH];
  bit    rdy_rand, en_rand, scr_rand, scr_now;
  int    checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < CH; k++) if (ch_len[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] log_d(input int i);
    if (i < obs_log.size()) return obs_log[i].d;
    return 'x;
  endfunction
  function automatic logic log_f(input int i);
    if (i < obs_log.size()) return obs_log[i].f;
    return 1'bx;
  endfunction
  function automatic logic log_l(input int i);
    if (i < obs_log.size()) return obs_log[i].l;
    return 1'bx;
  endfunction
  function automatic int win_at(input int i);
    if (i < win_log.size()) return win_log[i];
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < CH; k++) begin
      req_vec_i[k]           = (ch_len[k].size() > 0) && en[k];
      data_slv_i[k*DW +: DW] = (ch_words[k].size() > 0) ? ch_words[k][0] : '0;
      id_slv_i[k*LW +: LW]   = scr[k] ? scr_id[k]  : ((ch_len[k].size() > 0) ? ch_id[k][0]  : '0);
      len_slv_i[k*LW +: LW]  = scr[k] ? scr_len[k] : ((ch_len[k].size() > 0) ? ch_len[k][0] : '0);
    end
  endtask

  task automatic load(input int k, input logic [LW-1:0] id, input int len, input logic [DW-1:0] base);
    ch_id[k].push_back(id);
    ch_len[k].push_back(LW'(len));
    for (int i = 0; i < len; i++) ch_words[k].push_back(base + DW'(i));
  endtask

  // Start of a packet: choose the winner round-robin and build its word list.
  task automatic predict();
    int            w;
    int            k;
    logic [LW-1:0] len;
    logic [DW-1:0] hdr, par;
    word_t         e;
    w = -1;
    for (int i = 1; i <= CH; i++) begin
      k = (last_win + i) % CH;
      if (w < 0 && ch_len[k].size() > 0 && en[k]) w = k;
    end
    checks++;
    assert (w >= 0) else begin
      errors++;
      $error("FAIL arb_req: observed busy with no requester expected idle");
    end
    if (w < 0) return;
    len = ch_len[w][0];
    hdr = {ch_id[w][0], len, {(DW-2*LW){1'b0}}};
    par = hdr;
    e.d = hdr; e.f = 1'b1; e.l = (!PAR && len == 0); e.pay = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < int'(len); i++) begin
      e.d = ch_words[w][i]; e.f = 1'b0; e.l = (!PAR && i == int'(len) - 1); e.pay = 1'b1;
      par = par ^ e.d;
      exp_q.push_back(e);
    end
    if (PAR) begin
      e.d = par; e.f = 1'b0; e.l = 1'b1; e.pay = 1'b0;
      exp_q.push_back(e);
    end
    last_win  = w;
    act_ch    = w;
    act_len   = int'(len);
    active    = 1'b1;
    arb_ph    = 1'b1;
    fetch_cnt = 0;
    win_log.push_back(w);
  endtask

  // One clock: check outputs at the falling edge, update stimulus after the rising edge.
  task automatic cycle();
    word_t         e, o;
    bit            ev, done;
    logic [CH-1:0] efetch;
    @(negedge clk);
    efetch = '0;
    done   = 1'b0;
    for (int k = 0; k < CH; k++) if (fetch_vec_o[k]) fcount[k]++;
    if (want_idle) begin
      chk("idle_gap", busy_o, 1'b0);
      want_idle = 1'b0;
    end
    if (!active) begin
      if (busy_o) predict();
      else begin
        chk("idle_vld", pkg_vld_o, 1'b0);
        chk("idle_fetch", fetch_vec_o, '0);
      end
    end
    if (active) begin
      chk("busy", busy_o, 1'b1);
      chk("cur_ch", cur_ch_o, act_ch);
      if (arb_ph) begin
        chk("arb_vld", pkg_vld_o, 1'b0);
        chk("arb_fetch", fetch_vec_o, '0);
        arb_ph = 1'b0;
      end else begin
        e  = exp_q[0];
        ev = e.pay ? en[act_ch] : 1'b1;
        chk("vld", pkg_vld_o, ev);
        if (ev) begin
          chk("dat", pkg_dat_o, e.d);
          chk("fst", pkg_fst_o, e.f);
          chk("lst", pkg_lst_o, e.l);
        end
        if (ev && rev_rdy_i && e.pay) efetch = CH'(1 << act_ch);
        chk("fetch", fetch_vec_o, efetch);
        fetch_cnt += int'(fetch_vec_o[act_ch]);
        if (ev && rev_rdy_i) begin
          o.d = pkg_dat_o; o.f = pkg_fst_o; o.l = pkg_lst_o; o.pay = 1'b0;
          obs_log.push_back(o);
          void'(exp_q.pop_front());
          if (e.pay) pay_done++;
          if (exp_q.size() == 0) begin
            done = 1'b1;
            chk("fetch_count", fetch_cnt, act_len);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (efetch != '0) void'(ch_words[act_ch].pop_front());
    if (done) begin
      void'(ch_id[act_ch].pop_front());
      void'(ch_len[act_ch].pop_front());
      scr[act_ch] = 1'b0;
      for (int k = 0; k < CH; k++) en[k] = 1'b1;
      active    = 1'b0;
      want_idle = 1'b1;
    end
    if (rdy_rand) rev_rdy_i = ($urandom_range(0, 3) != 0);
    if (active && !arb_ph) begin
      if (en_rand) en[act_ch] = ($urandom_range(0, 3) != 0);
      if (scr_rand || scr_now) begin
        scr[act_ch]     = 1'b1;
        scr_id[act_ch]  = LW'($urandom);
        scr_len[act_ch] = LW'($urandom);
      end
    end
    drive_inputs();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((active || pending() || busy_o || want_idle) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL timeout: observed %0d cycles expected fewer than %0d", n, budget);
    end
  endtask

  task automatic run_until_pay(input int target, input int budget);
    int n;
    n = 0;
    while (pay_done < target && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL pay_timeout: observed %0d payload words expected %0d", pay_done, target);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_vld", pkg_vld_o, 1'b0);
    chk("rst_dat", pkg_dat_o, '0);
    chk("rst_fst", pkg_fst_o, 1'b0);
    chk("rst_lst", pkg_lst_o, 1'b0);
    chk("rst_fetch", fetch_vec_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cur_ch", cur_ch_o, '0);
    for (int k = 0; k < CH; k++) begin
      ch_words[k].delete(); ch_id[k].delete(); ch_len[k].delete();
      en[k] = 1'b1; scr[k] = 1'b0;
    end
    exp_q.delete();
    active = 1'b0; arb_ph = 1'b0; want_idle = 1'b0;
    last_win = CH - 1;
    drive_inputs();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic clear_logs();
    obs_log.delete();
    win_log.delete();
    pay_done = 0;
    for (int k = 0; k < CH; k++) fcount[k] = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rdy_rand = 0; en_rand = 0; scr_rand = 0; scr_now = 0;
    rev_rdy_i = 1'b1;
    data_slv_i = '0; id_slv_i = '0; len_slv_i = '0; req_vec_i = '0;
    for (int k = 0; k < CH; k++) begin
      en[k] = 1'b1; scr[k] = 1'b0; scr_id[k] = '0; scr_len[k] = '0; fcount[k] = 0;
    end
    active = 0; arb_ph = 0; want_idle = 0; last_win = CH - 1; pay_done = 0;

    // Reset state
    do_reset();
    $display("reset: outputs checked");

    // Single packet on ch1: id 0x11, len 2, data 0xA, 0xB
    clear_logs();
    load(1, 8'h11, 2, 32'hA);
    drive_inputs();
    run_idle(200);
    chk("basic_words", obs_log.size(), PAR ? 4 : 3);
    chk("basic_hdr", log_d(0), 32'h11020000);
    chk("basic_fst", log_f(0), 1'b1);
    chk("basic_w1", log_d(1), 32'hA);
    chk("basic_w2", log_d(2), 32'hB);
    if (PAR) begin
      chk("basic_par", log_d(3), 32'h11020001);
      chk("basic_lst", log_l(3), 1'b1);
    end else begin
      chk("basic_lst", log_l(2), 1'b1);
    end
    chk("basic_fetch1", fcount[1], 2);
    $display("basic packet ch1: %0d words", obs_log.size());

    // All four channels requesting continuously
    do_reset();
    clear_logs();
    for (int k = 0; k < CH; k++) begin
      load(k, LW'(8'h20 + k), 1 + k % 3, DW'(32'h1000 * (k + 1)));
      load(k, LW'(8'h30 + k), 2, DW'(32'h2000 * (k + 1)));
    end
    drive_inputs();
    run_idle(1000);
    chk("rr_g0", win_at(0), 0);
    chk("rr_g1", win_at(1), 1);
    chk("rr_g2", win_at(2), 2);
    chk("rr_g3", win_at(3), 3);
    chk("rr_g4", win_at(4), 0);
    $display("round robin: %0d packets", win_log.size());

    // len = 0 on ch2
    clear_logs();
    load(2, 8'h5A, 0, '0);
    drive_inputs();
    run_idle(200);
    chk("len0_words", obs_log.size(), PAR ? 2 : 1);
    chk("len0_hdr", log_d(0), 32'h5A000000);
    chk("len0_fst", log_f(0), 1'b1);
    if (PAR) begin
      chk("len0_par", log_d(1), 32'h5A000000);
      chk("len0_lst", log_l(1), 1'b1);
    end else begin
      chk("len0_lst", log_l(0), 1'b1);
    end
    $display("len0 ch2: %0d words", obs_log.size());

    // Stalls mid-payload: receiver not ready, then request withdrawn
    clear_logs();
    load(1, 8'h40, 4, 32'h100);
    drive_inputs();
    run_until_pay(1, 100);
    rev_rdy_i = 1'b0;
    repeat (3) cycle();
    rev_rdy_i = 1'b1;
    en[1] = 1'b0;
    drive_inputs();
    repeat (2) cycle();
    en[1] = 1'b1;
    drive_inputs();
    run_idle(200);
    chk("stall_words", obs_log.size(), PAR ? 6 : 5);
    chk("stall_w2", log_d(2), 32'h101);
    chk("stall_fetch1", fcount[1], 4);
    $display("stall ch1: %0d words", obs_log.size());

    // id/len changed on the inputs once the packet is under way
    clear_logs();
    scr_now = 1'b1;
    load(3, 8'h33, 3, 32'h300);
    drive_inputs();
    run_idle(200);
    scr_now = 1'b0;
    chk("latch_hdr", log_d(0), 32'h33030000);
    chk("latch_words", obs_log.size(), PAR ? 5 : 4);
    $display("latched len ch3: %0d words", obs_log.size());

    // Reset in the middle of a len=5 payload
    clear_logs();
    load(2, 8'h52, 5, 32'h500);
    drive_inputs();
    run_until_pay(2, 100);
    do_reset();
    clear_logs();
    load(1, 8'h61, 2, DW'($urandom));
    load(3, 8'h63, 1, DW'($urandom));
    drive_inputs();
    run_idle(300);
    chk("post_rst_first", win_at(0), 1);
    $display("reset mid-packet: next grant ch%0d", win_at(0));

    // Randomized traffic with random ready, request drops and input churn
    rdy_rand = 1; en_rand = 1; scr_rand = 1;
    for (int it = 0; it < 30; it++) begin
      int nl;
      clear_logs();
      nl = 0;
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          load(k, LW'($urandom), $urandom_range(0, 6), DW'($urandom));
          nl++;
        end
      end
      if (nl == 0) load($urandom_range(0, CH - 1), LW'($urandom), $urandom_range(0, 6), DW'($urandom));
      drive_inputs();
      run_idle(2000);
      $display("random %0d: %0d packets, %0d words", it, win_log.size(), obs_log.size());
    end
    rdy_rand = 0; en_rand = 0; scr_rand = 0;
    rev_rdy_i = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_formatter.md
MC_FORMATTER -- requirements
Module: mc_formatter

Interface
REQ-001 Parameter CH_NUM, default 4: number of slave channels, legal range 2..8.
REQ-002 Parameter DW, default 32: data and output word width, legal range 16..64.
REQ-003 Parameter LENW, default 8: width of the id and len fields; 2*LENW SHALL NOT exceed DW.
REQ-004 clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 rst_i  in  1  reset; asynchronous assert, active-high.
REQ-006 data_slv_i  in  CH_NUM*DW  channel k payload at bits [k*DW +: DW].
REQ-007 id_slv_i  in  CH_NUM*LENW  channel k id.
REQ-008 len_slv_i  in  CH_NUM*LENW  channel k payload word count.
REQ-009 req_vec_i  in  CH_NUM  channel k has a payload word available.
REQ-010 fetch_vec_o  out  CH_NUM  one-hot pop pulse to channel k for the current payload word.
REQ-011 rev_rdy_i  in  1  receiver ready.
REQ-012 pkg_vld_o, pkg_dat_o (DW), pkg_fst_o, pkg_lst_o  out  output word, valid, header flag, last flag.
REQ-013 busy_o  out  1  packet in progress.
REQ-014 cur_ch_o  out  $clog2(CH_NUM)  index of the granted channel.

Function
REQ-015 FSM states: IDLE, ARB, HEADER, PAYLOAD, PARITY.
REQ-016 IDLE->ARB when |req_vec_i. ARB->HEADER unconditionally.
REQ-017 HEADER->PAYLOAD on rdy when len!=0, else ->PARITY. PAYLOAD->PARITY on the accepted word with cnt==1. PARITY->IDLE on rdy.
REQ-018 ARB: round-robin grant from req_vec_i, starting at the channel after the last winner. The one-hot grant, id and len are latched and held until the packet ends.
REQ-019 A transfer occurs only on a cycle with pkg_vld_o && rev_rdy_i. Outputs stay stable while stalled.
REQ-020 HEADER: pkg_vld_o=1, pkg_fst_o=1, pkg_dat_o={id, len, zeros}.
REQ-021 PAYLOAD: pkg_vld_o=req_vec_i[grant] and pkg_dat_o=granted channel data. fetch_vec_o=grant on a transfer, else 0. The counter decrements per transfer.
REQ-022 Dropping the request mid-payload stalls the packet: pkg_vld_o=0, no fetch, no abort.
REQ-023 Exactly len payload words per packet. len=0 yields header followed by parity.
REQ-024 The parity register loads the header word on header transfer and XORs each payload word.
REQ-025 PARITY: pkg_vld_o=1, pkg_lst_o=1, pkg_dat_o=parity register.
REQ-026 Input len/id changes after ARB SHALL be ignored for the current packet.
REQ-027 busy_o=1 in every state except IDLE. cur_ch_o is valid while busy_o=1.
REQ-028 Minimum one IDLE cycle between packets. A request arriving during a packet waits for the next ARB.

Reset
REQ-029 rst_i forces state IDLE, RR pointer to give channel 0 top priority, and counter and parity to 0.
REQ-030 Under reset, all outputs are 0. Reset mid-packet abandons the packet without issuing pkg_lst_o.

Configuration
REQ-031 Macro MCF_PARITY_EN. When defined, behaviour is as above.
REQ-032 When MCF_PARITY_EN is undefined: no PARITY state and no parity register.
REQ-033 When undefined: pkg_lst_o is asserted with the final payload word, or with the header when len=0.
REQ-034 When undefined: the packet returns to IDLE on that transfer.

Structure
REQ-035 Package mcf_pkg holds the FSM state enum, the header field-position constants and a default-width localparam.
REQ-036 Round-robin grant logic is a sub-module mcf_rr_arb (req, advance, one-hot grant), instantiated once.

Verification
REQ-037 Ch1 only, id=0x11, len=2, data 0xA, 0xB, rdy=1:
  - Output: header 0x11020000, 0xA, 0xB, parity 0x11020001.
  - fst on word 1 and lst on word 4; two fetch pulses on bit1.
REQ-038 All four channels requesting continuously:
  - Grants follow 0,1,2,3,0.
  - Each packet is followed by an IDLE cycle.
REQ-039 len=0 on ch2: header then parity=header word. Without the macro: a single word with fst=lst=1.
REQ-040 rev_rdy_i low for 3 cycles mid-payload, and ch req low for 2 cycles:
  - Data is held and no fetch is issued while stalled.
  - Word count is unchanged.
REQ-041 rst_i pulsed during PAYLOAD of a len=5 packet:
  - Outputs 0 immediately.
  - The next packet starts from ch0 priority with correct parity.
REQ-042 len_slv_i changed during HEADER: the header and word count use the value latched in ARB.
